// File: rtl/sound_pkg.sv
// Shared types and note tables for the sound event scheduler.
package sound_pkg;

  typedef enum logic [1:0] {
    MEL_NONE   = 2'd0,
    MEL_BAD    = 2'd1,
    MEL_GOOD   = 2'd2,
    MEL_BUTTON = 2'd3
  } melody_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] LEN_BAD    = 2'd3;
  localparam logic [1:0] LEN_GOOD   = 2'd3;
  localparam logic [1:0] LEN_BUTTON = 2'd1;

  localparam logic [7:0] BAD_N0  = 8'd90;
  localparam logic [7:0] BAD_N1  = 8'd120;
  localparam logic [7:0] BAD_N2  = 8'd160;
  localparam logic [7:0] GOOD_N0 = 8'd60;
  localparam logic [7:0] GOOD_N1 = 8'd45;
  localparam logic [7:0] GOOD_N2 = 8'd30;
  localparam logic [7:0] BTN_N0  = 8'd40;

  function automatic logic [7:0] note_rom(melody_t mel, logic [1:0] idx);
    logic [7:0] p;
    p = 8'd0;
    case (mel)
      MEL_BAD: begin
        case (idx)
          2'd0:    p = BAD_N0;
          2'd1:    p = BAD_N1;
          default: p = BAD_N2;
        endcase
      end
      MEL_GOOD: begin
        case (idx)
          2'd0:    p = GOOD_N0;
          2'd1:    p = GOOD_N1;
          default: p = GOOD_N2;
        endcase
      end
      MEL_BUTTON: p = BTN_N0;
      default:    p = 8'd0;
    endcase
    return p;
  endfunction

  function automatic logic [1:0] mel_last(melody_t mel);
    logic [1:0] l;
    l = 2'd0;
    case (mel)
      MEL_BAD:    l = LEN_BAD - 2'd1;
      MEL_GOOD:   l = LEN_GOOD - 2'd1;
      MEL_BUTTON: l = LEN_BUTTON - 2'd1;
      default:    l = 2'd0;
    endcase
    return l;
  endfunction

  function automatic melody_t pick_melody(logic bad, logic good, logic btn);
    melody_t m;
    m = MEL_NONE;
    if (bad)       m = MEL_BAD;
    else if (good) m = MEL_GOOD;
    else if (btn)  m = MEL_BUTTON;
    return m;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter timing one NOTE or GAP phase; holds at zero.
module note_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nRst_i,
  input  logic         load_i,
  input  logic [W-1:0] count_i,
  output logic         done_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i)             r_cnt <= '0;
    else if (load_i)         r_cnt <= count_i;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign done_o = (r_cnt == '0);

endmodule

// File: rtl/sound_sequencer.sv
// Priority scheduler for game sound events; sequences melodies note by note
// into sound_generator. Handshake: event inputs are one-cycle strobes, no ready.
module sound_sequencer #(
  parameter int NOTE_CYCLES = 1_200_000,
  parameter int GAP_CYCLES  = 120_000
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic       button_i,
  output logic [7:0] notePeriod_o,
  output logic       soundEn_o,
  output logic [1:0] melody_o,
  output logic       busy_o,
  output logic [1:0] state_o
);
  import sound_pkg::*;

  localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] NOTE_LD = CW'(NOTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  melody_t    r_melody, w_mel_nxt, w_pick;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_pend_bad, r_pend_good, r_pend_btn;
  logic       w_req_bad, w_req_good, w_req_btn, w_any, w_start, w_preempt;
  logic       w_load, w_done;
  logic [CW-1:0] w_load_val;
  logic [7:0] r_period, w_period_nxt;
  logic       r_en, r_busy;

  note_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .nRst_i  (nRst_i),
    .load_i  (w_load),
    .count_i (w_load_val),
    .done_o  (w_done)
  );

  // Requests merge latched flags with this cycle's pulses.
  assign w_req_bad  = r_pend_bad  | badColl_i;
  assign w_req_good = r_pend_good | goodColl_i;
  assign w_req_btn  = r_pend_btn  | button_i;
  assign w_any      = w_req_bad | w_req_good | w_req_btn;
  assign w_pick     = pick_melody(w_req_bad, w_req_good, w_req_btn);
  assign w_preempt  = badColl_i && (r_melody == MEL_GOOD || r_melody == MEL_BUTTON);

  always_comb begin
    w_state_nxt = r_state;
    w_mel_nxt   = r_melody;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_val  = NOTE_LD;
    w_start     = 1'b0;
    case (r_state)
      IDLE: w_start = w_any;
      NOTE: begin
        if (w_preempt) begin
          w_start = 1'b1;
        end else if (w_done) begin
          w_state_nxt = GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LD;
        end
      end
      GAP: begin
        if (w_preempt) begin
          w_start = 1'b1;
        end else if (w_done) begin
          if (r_idx != mel_last(r_melody)) begin
            w_state_nxt = NOTE;
            w_idx_nxt   = r_idx + 2'd1;
            w_load      = 1'b1;
          end else if (w_any) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_mel_nxt   = MEL_NONE;
            w_idx_nxt   = 2'd0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = NOTE;
      w_mel_nxt   = w_pick;
      w_idx_nxt   = 2'd0;
      w_load      = 1'b1;
      w_load_val  = NOTE_LD;
    end
    w_period_nxt = (w_state_nxt == NOTE) ? note_rom(w_mel_nxt, w_idx_nxt) : 8'd0;
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_state     <= IDLE;
      r_melody    <= MEL_NONE;
      r_idx       <= 2'd0;
      r_pend_bad  <= 1'b0;
      r_pend_good <= 1'b0;
      r_pend_btn  <= 1'b0;
      r_period    <= 8'd0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_melody    <= w_mel_nxt;
      r_idx       <= w_idx_nxt;
      r_pend_bad  <= w_req_bad  && !(w_start && w_pick == MEL_BAD);
      r_pend_good <= w_req_good && !(w_start && w_pick == MEL_GOOD);
      r_pend_btn  <= w_req_btn  && !(w_start && w_pick == MEL_BUTTON);
      r_period    <= w_period_nxt;
      r_en        <= (w_state_nxt == NOTE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign notePeriod_o = r_period;
  assign soundEn_o    = r_en;
  assign melody_o     = r_melody;
  assign busy_o       = r_busy;
  assign state_o      = r_state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: timeline model of melody playback plus directed scenarios.
module tb_sound_sequencer;

  localparam int NC = 4;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       nRst_i = 1'b1;
  logic       goodColl_i = 1'b0;
  logic       badColl_i = 1'b0;
  logic       button_i = 1'b0;
  logic [7:0] notePeriod_o;
  logic       soundEn_o;
  logic [1:0] melody_o;
  logic       busy_o;
  logic [1:0] state_o;

  sound_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
    .clk          (clk),
    .nRst_i       (nRst_i),
    .goodColl_i   (goodColl_i),
    .badColl_i    (badColl_i),
    .button_i     (button_i),
    .notePeriod_o (notePeriod_o),
    .soundEn_o    (soundEn_o),
    .melody_o     (melody_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cur = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: a melody is a run of len*(NC+GC) cycles; position t
  // within it determines note index and whether a tone sounds.
  int m_mel = 0;
  int m_t = 0;
  bit p_bad = 0, p_good = 0, p_btn = 0;
  bit m_fin, m_pre;
  int rom_bad[3]  = '{90, 120, 160};
  int rom_good[3] = '{60, 45, 30};

  function automatic int mlen(int m);
    return (m == 3) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      m_mel = 0; m_t = 0; p_bad = 0; p_good = 0; p_btn = 0;
    end else begin
      m_fin = 0;
      if (m_mel != 0) begin
        m_t++;
        if (m_t == mlen(m_mel) * (NC + GC)) m_fin = 1;
      end
      m_pre = badColl_i && (m_mel == 2 || m_mel == 3);
      p_bad  = p_bad  | badColl_i;
      p_good = p_good | goodColl_i;
      p_btn  = p_btn  | button_i;
      if (m_mel == 0 || m_fin || m_pre) begin
        m_t = 0;
        if (p_bad)       begin m_mel = 1; p_bad = 0;  end
        else if (p_good) begin m_mel = 2; p_good = 0; end
        else if (p_btn)  begin m_mel = 3; p_btn = 0;  end
        else             m_mel = 0;
      end
    end
  end

  function automatic int e_en();
    if (m_mel == 0) return 0;
    return ((m_t % (NC + GC)) < NC) ? 1 : 0;
  endfunction

  function automatic int e_period();
    int idx;
    if (e_en() == 0) return 0;
    idx = m_t / (NC + GC);
    if (m_mel == 1) return rom_bad[idx];
    if (m_mel == 2) return rom_good[idx];
    return 40;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_period", notePeriod_o, e_period());
      chk("model_en", soundEn_o, e_en());
      chk("model_melody", melody_o, m_mel);
      chk("model_busy", busy_o, (m_mel != 0) ? 1 : 0);
      chk("model_state_idle", (state_o == 2'd0) ? 1 : 0, (m_mel == 0) ? 1 : 0);
    end
  end

  task automatic pulse(input bit g, input bit b, input bit n);
    goodColl_i = g; badColl_i = b; button_i = n;
    @(negedge clk);
    goodColl_i = 0; badColl_i = 0; button_i = 0;
    cur++;
  endtask

  task automatic goto(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_o && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    count_busy(n);
    chk("idle_timeout", busy_o, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    #1 nRst_i = 0;
    repeat (2) @(negedge clk);
    nRst_i = 1;
    chk_en = 1;
    chk("reset_period", notePeriod_o, 0);
    chk("reset_en", soundEn_o, 0);
    chk("reset_melody", melody_o, 0);
    chk("reset_busy", busy_o, 0);

    // Asynchronous reset in the middle of a note.
    cur = 0; pulse(1, 0, 0); goto(2);
    chk("pre_reset_period", notePeriod_o, 60);
    #2 nRst_i = 0;
    #1;
    chk("async_period", notePeriod_o, 0);
    chk("async_en", soundEn_o, 0);
    chk("async_melody", melody_o, 0);
    chk("async_busy", busy_o, 0);
    @(negedge clk); nRst_i = 1;
    repeat (5) @(negedge clk);
    chk("post_reset_busy", busy_o, 0);
    chk("post_reset_period", notePeriod_o, 0);

    // Single GOOD melody timeline.
    cur = 0; pulse(1, 0, 0);
    chk("good_c1", notePeriod_o, 60);
    goto(4);  chk("good_c4", notePeriod_o, 60);
    goto(5);  chk("good_c5", notePeriod_o, 0); chk("good_c5_en", soundEn_o, 0);
    goto(7);  chk("good_c7", notePeriod_o, 45);
    goto(13); chk("good_c13", notePeriod_o, 30);
    goto(17); chk("good_c17", notePeriod_o, 0);
    goto(18); chk("good_c18_busy", busy_o, 1); chk("good_c18_mel", melody_o, 2);
    goto(19); chk("good_c19_busy", busy_o, 0); chk("good_c19_mel", melody_o, 0);
    wait_idle();

    // BUTTON then queued GOOD, no idle cycle between them.
    cur = 0; pulse(0, 0, 1); goto(2); pulse(1, 0, 0);
    goto(4); chk("queue_c4", notePeriod_o, 40);
    goto(5); chk("queue_c5", notePeriod_o, 0);
    goto(6); chk("queue_c6_mel", melody_o, 3);
    goto(7); chk("queue_c7", notePeriod_o, 60); chk("queue_c7_mel", melody_o, 2);
    wait_idle();

    // BAD preempts GOOD during a note; GOOD is dropped.
    cur = 0; pulse(1, 0, 0); goto(3); pulse(0, 1, 0);
    chk("preempt_c4", notePeriod_o, 90); chk("preempt_c4_mel", melody_o, 1);
    goto(21); chk("preempt_c21_busy", busy_o, 1);
    goto(22); chk("preempt_c22_busy", busy_o, 0);
    wait_idle();

    // BAD preempts BUTTON during its gap.
    cur = 0; pulse(0, 0, 1); goto(5); pulse(0, 1, 0);
    chk("preempt_gap_c6", notePeriod_o, 90);
    count_busy(n); chk("preempt_gap_busy", n, 18);
    wait_idle();

    // All three at once: BAD, GOOD, BUTTON back to back.
    cur = 0; pulse(1, 1, 1);
    chk("simul_c1_mel", melody_o, 1);
    count_busy(n); chk("simul_busy", n, 42);
    wait_idle();

    // Duplicate BUTTON requests collapse to one replay.
    cur = 0; pulse(0, 0, 1); goto(2); pulse(0, 0, 1); goto(4); pulse(0, 0, 1);
    goto(7); chk("dup_c7", notePeriod_o, 40);
    count_busy(n); chk("dup_busy", n, 6);
    wait_idle();

    // BAD during BAD replays once.
    cur = 0; pulse(0, 1, 0); goto(5); pulse(0, 1, 0);
    count_busy(n); chk("bad_replay_busy", n, 31);
    wait_idle();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
